fetch_unit: RTL and testbench

Instruction fetch stage for the rv32 core. It holds the program counter and issues word-aligned requests to instruction memory over a valid/ready request channel, keeping at most two requests in flight. Responses are buffered in order in a 2-entry FIFO and presented to the decode stage with a valid/ready handshake. The decode side receives pre-split `opcode`/`func3`/`func7` fields for the control unit. A redirect from execute (branch/jump) restarts fetch at a new PC and discards all stale instructions.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, credit-limited request issue (two in flight),
// in-order tag queue, 2-entry decode FIFO, and redirect flush with stale-response drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_func3,
    output logic [6:0]  id_func7
);

    logic [31:0] pc;
    logic [1:0]  inflight;
    logic [1:0]  drop;
    logic [1:0]  count;

    logic [31:0] tag_q [2];
    logic        tag_wr;
    logic        tag_rd;

    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        wr_ptr;
    logic        rd_ptr;

    logic        pop;
    logic        req_fire;
    logic        push;
    logic [2:0]  credit_used;
    logic [31:0] head_instr;
    logic [31:0] head_pc;

    // Outstanding requests (stale ones included) plus buffered words may not exceed two,
    // which is what guarantees every kept response a FIFO slot.
    assign pop         = id_valid & id_ready;
    assign credit_used = {1'b0, inflight} + {1'b0, count} - {2'b00, pop};
    assign req_fire    = imem_req_valid & imem_req_ready;
    assign push        = imem_rsp_valid & (drop == 2'd0) & ~redirect_valid;

    assign imem_req_valid = ~rst & ~redirect_valid & (credit_used < 3'd2);
    assign imem_req_addr  = pc;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            inflight <= 2'd0;
            drop     <= 2'd0;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            tag_wr   <= 1'b0;
            tag_rd   <= 1'b0;
        end else begin
            inflight <= inflight + {1'b0, req_fire} - {1'b0, imem_rsp_valid};
            if (req_fire) begin
                tag_wr <= ~tag_wr;
            end
            if (imem_rsp_valid) begin
                tag_rd <= ~tag_rd;
            end

            if (redirect_valid) begin
                // Everything still outstanding after this edge belongs to the old stream.
                pc     <= redirect_pc & 32'hFFFF_FFFC;
                drop   <= inflight - {1'b0, imem_rsp_valid};
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (imem_rsp_valid && drop != 2'd0) begin
                    drop <= drop - 2'd1;
                end
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // NOTE: storage arrays carry no reset; validity is tracked by the counters and pointers,
    // so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr] <= pc;
        end
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]    <= tag_q[tag_rd];
        end
    end

    assign head_instr = fifo_instr[rd_ptr];
    assign head_pc    = fifo_pc[rd_ptr];

    // NOTE: every output gets a default before the conditional so no latch is inferred.
    always_comb begin
        id_valid    = (count != 2'd0);
        id_instr    = 32'd0;
        id_pc       = 32'd0;
        id_pc_plus4 = 32'd0;
        if (id_valid) begin
            id_instr    = head_instr;
            id_pc       = head_pc;
            id_pc_plus4 = head_pc + 32'd4;
        end
        // Idle slot decodes as opcode 0 so the control unit falls to its default.
        id_opcode = id_instr[6:0];
        id_func3  = id_instr[14:12];
        id_func7  = id_instr[31:25];
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a fixed-latency in-order memory model feeds the DUT and
// each scenario task checks hand-computed PCs, handshakes and decode fields per cycle.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [6:0]  id_opcode;
    logic [2:0]  id_func3;
    logic [6:0]  id_func7;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_opcode      (id_opcode),
        .id_func3       (id_func3),
        .id_func7       (id_func7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0300) return 32'h4020_5033;
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: accepts handshakes seen mid-cycle, answers exactly lat cycles later.
    always @(negedge clk) begin
        if (rst) mq.delete();
        else if (imem_req_valid === 1'b1 && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
    end

    always @(posedge clk) begin
        mreq_t h;
        cyc = cyc + 1;
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            h = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(h.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Leaves the bench at the start of cycle 0: the first cycle with rst low.
    task automatic do_reset(input int l);
        next();
        rst = 1'b1; lat = l; redirect_valid = 1'b0; redirect_pc = 32'd0;
        id_ready = 1'b1; imem_req_ready = 1'b1;
        next();
        next();
        sample();
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
        checks++; if (imem_req_addr !== 32'h100) begin failures++; $display("FAIL rst_req_addr got=%h exp=00000100", imem_req_addr); end
        next();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next();
        next();
        sample();
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h100) begin failures++; $display("FAIL reset_req_addr got=%h exp=00000100", imem_req_addr); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        checks++; if (id_instr !== 32'd0) begin failures++; $display("FAIL reset_id_instr got=%h exp=0", id_instr); end
        checks++; if (id_pc !== 32'd0) begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
        checks++; if (id_pc_plus4 !== 32'd0) begin failures++; $display("FAIL reset_id_pc_plus4 got=%h exp=0", id_pc_plus4); end
        checks++; if (id_opcode !== 7'd0) begin failures++; $display("FAIL reset_id_opcode got=%h exp=0", id_opcode); end
        checks++; if (id_func3 !== 3'd0) begin failures++; $display("FAIL reset_id_func3 got=%h exp=0", id_func3); end
        checks++; if (id_func7 !== 7'd0) begin failures++; $display("FAIL reset_id_func7 got=%h exp=0", id_func7); end
    endtask

    task automatic test_stream();
        logic [31:0] ep;
        next();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next();
            sample();
            ep = 32'h100 + 32'(4 * (k - 2));
            checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL stream_req_valid k=%0d got=%b exp=1", k, imem_req_valid); end
            checks++; if (imem_req_addr !== 32'h100 + 32'(4 * k)) begin failures++; $display("FAIL stream_req_addr k=%0d got=%h exp=%h", k, imem_req_addr, 32'h100 + 32'(4 * k)); end
            if (k < 2) begin
                checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stream_id_valid k=%0d got=%b exp=0", k, id_valid); end
            end else begin
                checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL stream_id_valid k=%0d got=%b exp=1", k, id_valid); end
                checks++; if (id_pc !== ep) begin failures++; $display("FAIL stream_id_pc k=%0d got=%h exp=%h", k, id_pc, ep); end
                checks++; if (id_instr !== mem_word(ep)) begin failures++; $display("FAIL stream_id_instr k=%0d got=%h exp=%h", k, id_instr, mem_word(ep)); end
                checks++; if (id_pc_plus4 !== ep + 32'd4) begin failures++; $display("FAIL stream_id_pc_plus4 k=%0d got=%h exp=%h", k, id_pc_plus4, ep + 32'd4); end
            end
        end
    endtask

    // Continues the stream: head 0x118 is held while the FIFO fills, then the stream resumes.
    task automatic test_backpressure();
        next();
        id_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) next();
            sample();
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'h118) begin failures++; $display("FAIL bp_hold_head j=%0d got=%b/%h exp=1/00000118", j, id_valid, id_pc); end
            checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_no_issue j=%0d got=%b exp=0", j, imem_req_valid); end
            checks++; if (imem_req_addr !== 32'h120) begin failures++; $display("FAIL bp_req_addr j=%0d got=%h exp=00000120", j, imem_req_addr); end
        end
        next();
        id_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) next();
            sample();
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'h118 + 32'(4 * j)) begin failures++; $display("FAIL bp_drain_pc j=%0d got=%b/%h exp=1/%h", j, id_valid, id_pc, 32'h118 + 32'(4 * j)); end
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h120 + 32'(4 * j)) begin failures++; $display("FAIL bp_drain_req j=%0d got=%b/%h exp=1/%h", j, imem_req_valid, imem_req_addr, 32'h120 + 32'(4 * j)); end
        end
    endtask

    task automatic test_redirect_stale();
        do_reset(3);
        sample();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin failures++; $display("FAIL stale_req0 got=%b/%h exp=1/00000100", imem_req_valid, imem_req_addr); end
        next(); sample();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104) begin failures++; $display("FAIL stale_req1 got=%b/%h exp=1/00000104", imem_req_valid, imem_req_addr); end
        next();
        redirect_valid = 1'b1; redirect_pc = 32'h2000;
        sample();
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stale_redirect_no_issue got=%b exp=0", imem_req_valid); end
        next();
        redirect_valid = 1'b0;
        sample();
        checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h2000) begin failures++; $display("FAIL stale_credit_wait got=%b/%h exp=0/00002000", imem_req_valid, imem_req_addr); end
        for (int c = 3; c <= 7; c++) begin
            if (c > 3) next();
            if (c > 3) sample();
            checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stale_discard cyc=%0d got=%b/%h exp=0", c, id_valid, id_pc); end
            if (c == 4) begin
                checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000) begin failures++; $display("FAIL stale_new_req got=%b/%h exp=1/00002000", imem_req_valid, imem_req_addr); end
            end
        end
        next(); sample();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h2000) begin failures++; $display("FAIL stale_first_pc got=%b/%h exp=1/00002000", id_valid, id_pc); end
        checks++; if (id_instr !== mem_word(32'h2000)) begin failures++; $display("FAIL stale_first_instr got=%h exp=%h", id_instr, mem_word(32'h2000)); end
        next(); sample();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h2004) begin failures++; $display("FAIL stale_second_pc got=%b/%h exp=1/00002004", id_valid, id_pc); end
    endtask

    task automatic test_redirect_collide();
        do_reset(1);
        next(); next(); next();
        sample();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h104) begin failures++; $display("FAIL col_pre_pc got=%b/%h exp=1/00000104", id_valid, id_pc); end
        next();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        sample();
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL col_no_issue got=%b exp=0", imem_req_valid); end
        next();
        redirect_valid = 1'b0;
        sample();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL col_flushed got=%b exp=0", id_valid); end
        checks++; if (id_instr !== 32'd0 || id_pc !== 32'd0 || id_pc_plus4 !== 32'd0) begin failures++; $display("FAIL col_idle_zero got=%h/%h/%h exp=0/0/0", id_instr, id_pc, id_pc_plus4); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin failures++; $display("FAIL col_next_req got=%b/%h exp=1/00000040", imem_req_valid, imem_req_addr); end
        next(); sample();
        checks++; if (id_valid !== 1'b0 || imem_req_addr !== 32'h44) begin failures++; $display("FAIL col_gap got=%b/%h exp=0/00000044", id_valid, imem_req_addr); end
        next(); sample();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin failures++; $display("FAIL col_first_pc got=%b/%h exp=1/00000040", id_valid, id_pc); end
        next(); sample();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h44) begin failures++; $display("FAIL col_second_pc got=%b/%h exp=1/00000044", id_valid, id_pc); end
    endtask

    task automatic test_fields();
        do_reset(1);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        sample();
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL fld_redirect_no_issue got=%b exp=0", imem_req_valid); end
        next();
        redirect_valid = 1'b0;
        sample();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin failures++; $display("FAIL fld_req got=%b/%h exp=1/00000300", imem_req_valid, imem_req_addr); end
        next();
        imem_req_ready = 1'b0;
        sample();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL fld_latency got=%b exp=0", id_valid); end
        next(); sample();
        checks++; if (id_valid !== 1'b1 || id_instr !== 32'h4020_5033) begin failures++; $display("FAIL fld_instr got=%b/%h exp=1/40205033", id_valid, id_instr); end
        checks++; if (id_opcode !== 7'h33) begin failures++; $display("FAIL fld_opcode got=%h exp=33", id_opcode); end
        checks++; if (id_func3 !== 3'd5) begin failures++; $display("FAIL fld_func3 got=%h exp=5", id_func3); end
        checks++; if (id_func7 !== 7'h20) begin failures++; $display("FAIL fld_func7 got=%h exp=20", id_func7); end
        checks++; if (id_pc !== 32'h300 || id_pc_plus4 !== 32'h304) begin failures++; $display("FAIL fld_pc got=%h/%h exp=00000300/00000304", id_pc, id_pc_plus4); end
        next(); sample();
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'd0 || id_pc !== 32'd0 || id_pc_plus4 !== 32'd0) begin failures++; $display("FAIL fld_idle got=%b/%h/%h/%h exp=0/0/0/0", id_valid, id_instr, id_pc, id_pc_plus4); end
        checks++; if (id_opcode !== 7'd0 || id_func3 !== 3'd0 || id_func7 !== 7'd0) begin failures++; $display("FAIL fld_idle_fields got=%h/%h/%h exp=0/0/0", id_opcode, id_func3, id_func7); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h304) begin failures++; $display("FAIL fld_req_unaccepted got=%b/%h exp=1/00000304", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_wrap();
        do_reset(1);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        sample();
        next();
        redirect_valid = 1'b0;
        sample();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_aligned got=%b/%h exp=1/fffffffc", imem_req_valid, imem_req_addr); end
        next(); sample();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_req got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr); end
        next(); sample();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_id_pc got=%b/%h exp=1/fffffffc", id_valid, id_pc); end
        checks++; if (id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc_plus4 got=%h exp=00000000", id_pc_plus4); end
        checks++; if (id_instr !== mem_word(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_instr got=%h exp=%h", id_instr, mem_word(32'hFFFF_FFFC)); end
        next(); sample();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin failures++; $display("FAIL wrap_after got=%b/%h/%h exp=1/0/4", id_valid, id_pc, id_pc_plus4); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_collide();
        test_fields();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
